// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative Y86 OPq ALU.
// Holds the ifun encodings and the controller state enum.
package alu_pkg;

  localparam logic [1:0] IFUN_ADD = 2'd0;
  localparam logic [1:0] IFUN_SUB = 2'd1;
  localparam logic [1:0] IFUN_AND = 2'd2;
  localparam logic [1:0] IFUN_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [1:0] f);
    return (f == IFUN_ADD) || (f == IFUN_SUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: one CHUNK-wide slice of ADD/SUB/AND/XOR.
// Ports: a, b (slices), ifun, cin -> res, cout (cin passed through for AND/XOR).
module alu_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       ifun,
  input  logic             cin,
  output logic [CHUNK-1:0] res,
  output logic             cout
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  always_comb begin
    bx   = (ifun == IFUN_SUB) ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};
    res  = sum[CHUNK-1:0];
    cout = cin;
    unique case (1'b1)
      (ifun == IFUN_AND): res = a & b;
      (ifun == IFUN_XOR): res = a ^ b;
      default:            cout = sum[CHUNK];
    endcase
  end

endmodule

// File: rtl/alu_cc_iter.sv
// alu_cc_iter: multi-cycle Y86 OPq ALU, CHUNK bits per clock, with CC register.
// Ports: clk, rst, in_valid/in_ready, ifun, a, b, set_cc, out_valid/out_ready,
//        result, cout, zf, sf, of, cc_zf, cc_sf, cc_of.
module alu_cc_iter
  import alu_pkg::*;
#(
  parameter int W     = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         set_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam int N  = W / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           zrun_q, zrun_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     ifun_q, ifun_d;
  logic           set_cc_q, set_cc_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           zf_q, zf_d;
  logic           sf_q, sf_d;
  logic           of_q, of_d;
  logic           cc_zf_q, cc_zf_d;
  logic           cc_sf_q, cc_sf_d;
  logic           cc_of_q, cc_of_d;

  logic [CHUNK-1:0] s_a, s_b, s_res;
  logic             s_cout;
  logic             last_slice;
  logic             msb_r;

  assign s_a = a_q[idx_q*CHUNK +: CHUNK];
  assign s_b = b_q[idx_q*CHUNK +: CHUNK];

  alu_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .ifun (ifun_q),
    .cin  (carry_q),
    .res  (s_res),
    .cout (s_cout)
  );

  assign last_slice = (state_q == BUSY) && (idx_q == LAST);
  assign msb_r      = s_res[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zrun_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ifun_q   <= IFUN_ADD;
      set_cc_q <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      cc_zf_q  <= 1'b0;
      cc_sf_q  <= 1'b0;
      cc_of_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zrun_q   <= zrun_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ifun_q   <= ifun_d;
      set_cc_q <= set_cc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
      cc_zf_q  <= cc_zf_d;
      cc_sf_q  <= cc_sf_d;
      cc_of_q  <= cc_of_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    zrun_d   = zrun_q;
    a_d      = a_q;
    b_d      = b_q;
    ifun_d   = ifun_q;
    set_cc_d = set_cc_q;
    result_d = result_q;
    cout_d   = cout_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    cc_zf_d  = cc_zf_q;
    cc_sf_d  = cc_sf_q;
    cc_of_d  = cc_of_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          ifun_d   = ifun;
          set_cc_d = set_cc;
          idx_d    = '0;
          // SUB is a + ~b + 1: the +1 enters as the first slice's carry-in
          carry_d  = (ifun == IFUN_SUB);
          zrun_d   = 1'b1;
        end
      end
      BUSY: begin
        result_d[idx_q*CHUNK +: CHUNK] = s_res;
        carry_d = s_cout;
        zrun_d  = zrun_q & ~|s_res;
        // park the index at 0 so the slice mux never reads past the operand
        idx_d   = last_slice ? '0 : idx_q + IW'(1);
        if (last_slice) begin
          zf_d   = zrun_d;
          sf_d   = msb_r;
          cout_d = is_arith(ifun_q) & s_cout;
          unique case (ifun_q)
            IFUN_ADD: of_d = (a_q[W-1] == b_q[W-1]) && (msb_r != a_q[W-1]);
            IFUN_SUB: of_d = (a_q[W-1] != b_q[W-1]) && (msb_r != a_q[W-1]);
            default:  of_d = 1'b0;
          endcase
        end
      end
      DONE: begin
        if (out_ready && set_cc_q) begin
          cc_zf_d = zf_q;
          cc_sf_d = sf_q;
          cc_of_d = of_q;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign cc_zf     = cc_zf_q;
  assign cc_sf     = cc_sf_q;
  assign cc_of     = cc_of_q;

endmodule

// File: tb/tb_alu_cc_iter.sv
// tb_alu_cc_iter: randomized and directed bench for alu_cc_iter.
// Drives at negedge, samples at negedge; reference model uses wide arithmetic.
module tb_alu_cc_iter;

  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;
  localparam logic [1:0] F_XOR = 2'd3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic        out_ready = 1'b0, out_ready2 = 1'b0;
  logic [1:0]  ifun = 2'd0;
  logic [63:0] a = '0, b = '0;
  logic        set_cc = 1'b0;
  logic        in_ready, out_valid, cout, zf, sf, of, cc_zf, cc_sf, cc_of;
  logic [63:0] result;
  logic        in_ready2, out_valid2, cout2, zf2, sf2, of2;
  logic        cc2_zf, cc2_sf, cc2_of;
  logic [63:0] result2;

  int   chk = 0;
  int   err = 0;
  logic [2:0] cc_m = 3'b000;
  logic [2:0] cc2_m = 3'b000;

  always #5 clk = ~clk;

  alu_cc_iter #(.W(64), .CHUNK(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ifun(ifun), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zf(zf), .sf(sf), .of(of),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  alu_cc_iter #(.W(64), .CHUNK(64)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .ifun(ifun), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .cout(cout2), .zf(zf2), .sf(sf2), .of(of2),
    .cc_zf(cc2_zf), .cc_sf(cc2_sf), .cc_of(cc2_of)
  );

  function automatic exp_t ref_op(input logic [63:0] x, input logic [63:0] y,
                                  input logic [1:0] f);
    exp_t e;
    logic [64:0] wide;
    logic signed [65:0] sx, sy, s;
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    e = '0;
    s = '0;
    case (f)
      F_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        e.res = wide[63:0];
        e.cout = wide[64];
        s = sx + sy;
      end
      F_SUB: begin
        e.res = x - y;
        e.cout = (x >= y);
        s = sx - sy;
      end
      F_AND: e.res = x & y;
      default: e.res = x ^ y;
    endcase
    // true signed value must fit in 64 bits, else overflow
    e.of = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
    e.zf = (e.res == 64'd0);
    e.sf = e.res[63];
    return e;
  endfunction

  task automatic issue(input logic [63:0] x, input logic [63:0] y,
                       input logic [1:0] f, input logic sc, output int lat);
    a = x; b = y; ifun = f; set_cc = sc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic hand(input logic sc, input exp_t e);
    out_ready = 1'b1;
    @(posedge clk);
    if (sc) cc_m = {e.zf, e.sf, e.of};
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err++;
      $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
    end
    chk++;
    if ({result, cout, zf, sf, of} !== 68'd0) begin
      err++;
      $display("FAIL reset_out: got %h want 0", {result, cout, zf, sf, of});
    end
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
      err++;
      $display("FAIL reset_cc: got %b want 000", {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_sub_basic;
    int lat;
    exp_t e;
    e = ref_op(64'd15, 64'd10, F_SUB);
    issue(64'd15, 64'd10, F_SUB, 1'b1, lat);
    chk++;
    if (lat !== 4) begin
      err++;
      $display("FAIL sub_latency: got %0d want 4", lat);
    end
    chk++;
    if ({result, cout, zf, sf, of} !== {64'd5, 4'b1000}) begin
      err++;
      $display("FAIL sub15_10: got %h want %h", {result, cout, zf, sf, of},
               {64'd5, 4'b1000});
    end
    chk++;
    if ({result, cout, zf, sf, of} !== e) begin
      err++;
      $display("FAIL sub15_10_model: got %h want %h",
               {result, cout, zf, sf, of}, e);
    end
    hand(1'b1, e);
    chk++;
    if ({in_ready, cc_zf, cc_sf, cc_of} !== {1'b1, cc_m}) begin
      err++;
      $display("FAIL sub15_10_cc: got %b want %b",
               {in_ready, cc_zf, cc_sf, cc_of}, {1'b1, cc_m});
    end
  endtask

  task automatic test_wrap;
    int lat;
    exp_t e;
    logic [63:0] xs [2] = '{64'd10, 64'd0};
    logic [63:0] ys [2] = '{64'd15, 64'd1};
    for (int i = 0; i < 2; i++) begin
      e = ref_op(xs[i], ys[i], F_SUB);
      issue(xs[i], ys[i], F_SUB, 1'b0, lat);
      chk++;
      if ({result, cout, zf, sf, of} !== e) begin
        err++;
        $display("FAIL wrap_%0d: got %h want %h", i,
                 {result, cout, zf, sf, of}, e);
      end
      hand(1'b0, e);
    end
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== cc_m) begin
      err++;
      $display("FAIL wrap_cc_hold: got %b want %b",
               {cc_zf, cc_sf, cc_of}, cc_m);
    end
  endtask

  task automatic test_zero_cc;
    int lat;
    exp_t e;
    e = ref_op(64'd0, 64'd0, F_SUB);
    issue(64'd0, 64'd0, F_SUB, 1'b1, lat);
    chk++;
    if ({result, cout, zf, sf, of} !== e) begin
      err++;
      $display("FAIL sub0_0: got %h want %h", {result, cout, zf, sf, of}, e);
    end
    hand(1'b1, e);
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      err++;
      $display("FAIL sub0_0_cc: got %b want 100", {cc_zf, cc_sf, cc_of});
    end
    e = ref_op(ONES, 64'd1, F_SUB);
    issue(ONES, 64'd1, F_SUB, 1'b0, lat);
    chk++;
    if ({result, cout, zf, sf, of} !== e) begin
      err++;
      $display("FAIL subff_1: got %h want %h", {result, cout, zf, sf, of}, e);
    end
    hand(1'b0, e);
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      err++;
      $display("FAIL subff_1_cc_hold: got %b want 100", {cc_zf, cc_sf, cc_of});
    end
  endtask

  task automatic test_add_of;
    int lat;
    exp_t e;
    e = ref_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F_ADD);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, F_ADD, 1'b1, lat);
    chk++;
    if ({result, cout, zf, sf, of} !== {64'h8000_0000_0000_0000, 4'b0011}) begin
      err++;
      $display("FAIL add_of: got %h want %h", {result, cout, zf, sf, of},
               {64'h8000_0000_0000_0000, 4'b0011});
    end
    hand(1'b1, e);
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      err++;
      $display("FAIL add_of_cc: got %b want 011", {cc_zf, cc_sf, cc_of});
    end
    e = ref_op(64'hF0F0, 64'hFFFF, F_XOR);
    issue(64'hF0F0, 64'hFFFF, F_XOR, 1'b0, lat);
    chk++;
    if ({result, cout, zf, sf, of} !== e) begin
      err++;
      $display("FAIL xor: got %h want %h", {result, cout, zf, sf, of}, e);
    end
    hand(1'b0, e);
  endtask

  task automatic test_back_to_back;
    int lat;
    exp_t e1, e2;
    logic [63:0] x2, y2;
    e1 = ref_op(64'd1000, 64'd7, F_ADD);
    issue(64'd1000, 64'd7, F_ADD, 1'b0, lat);
    x2 = {$urandom, $urandom};
    y2 = {$urandom, $urandom};
    e2 = ref_op(x2, y2, F_SUB);
    a = x2; b = y2; ifun = F_SUB; set_cc = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk++;
      if ({out_valid, in_ready, result} !== {2'b10, e1.res}) begin
        err++;
        $display("FAIL bp_hold_%0d: got %h want %h", i,
                 {out_valid, in_ready, result}, {2'b10, e1.res});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err++;
      $display("FAIL bp_after_hs: got %b want 10", {in_ready, out_valid});
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk++;
    if (in_ready !== 1'b0) begin
      err++;
      $display("FAIL bp_accept: got %b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk++;
    if ({lat[7:0], result, cout, zf, sf, of} !== {8'd4, e2}) begin
      err++;
      $display("FAIL bp_second: got %h want %h",
               {lat[7:0], result, cout, zf, sf, of}, {8'd4, e2});
    end
    hand(1'b1, e2);
  endtask

  task automatic test_reset_busy;
    int lat;
    exp_t e;
    e = ref_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, F_ADD);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, F_ADD, 1'b1, lat);
    hand(1'b1, e);
    chk++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b101) begin
      err++;
      $display("FAIL rb_pre_cc: got %b want 101", {cc_zf, cc_sf, cc_of});
    end
    a = 64'd99; b = 64'd3; ifun = F_SUB; set_cc = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cc_m = 3'b000;
    chk++;
    if ({in_ready, out_valid, cc_zf, cc_sf, cc_of} !== 5'b10000) begin
      err++;
      $display("FAIL rb_abort: got %b want 10000",
               {in_ready, out_valid, cc_zf, cc_sf, cc_of});
    end
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk++;
    if (lat !== 0) begin
      err++;
      $display("FAIL rb_no_result: got %0d valid cycles want 0", lat);
    end
    e = ref_op(64'd15, 64'd10, F_SUB);
    issue(64'd15, 64'd10, F_SUB, 1'b0, lat);
    chk++;
    if ({lat[7:0], result, cout, zf, sf, of} !== {8'd4, e}) begin
      err++;
      $display("FAIL rb_resume: got %h want %h",
               {lat[7:0], result, cout, zf, sf, of}, {8'd4, e});
    end
    hand(1'b0, e);
  endtask

  task automatic test_single_cycle;
    int lat;
    exp_t e;
    logic [63:0] xs [3] = '{64'd15, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0};
    logic [63:0] ys [3] = '{64'd10, 64'd1, 64'd1};
    logic [1:0]  fs [3] = '{F_SUB, F_ADD, F_SUB};
    for (int i = 0; i < 3; i++) begin
      e = ref_op(xs[i], ys[i], fs[i]);
      a = xs[i]; b = ys[i]; ifun = fs[i]; set_cc = 1'b1; in_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      chk++;
      if ({lat[7:0], result2, cout2, zf2, sf2, of2} !== {8'd1, e}) begin
        err++;
        $display("FAIL c64_%0d: got %h want %h", i,
                 {lat[7:0], result2, cout2, zf2, sf2, of2}, {8'd1, e});
      end
      out_ready2 = 1'b1;
      @(posedge clk);
      cc2_m = {e.zf, e.sf, e.of};
      @(negedge clk);
      out_ready2 = 1'b0;
      chk++;
      if ({in_ready2, cc2_zf, cc2_sf, cc2_of} !== {1'b1, cc2_m}) begin
        err++;
        $display("FAIL c64_cc_%0d: got %b want %b", i,
                 {in_ready2, cc2_zf, cc2_sf, cc2_of}, {1'b1, cc2_m});
      end
    end
  endtask

  task automatic test_random;
    int lat;
    exp_t e;
    logic [63:0] x, y;
    logic [1:0] f;
    logic sc;
    for (int i = 0; i < 40; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      f = 2'($urandom_range(0, 3));
      sc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: y = x;
        1: begin x = 64'($urandom_range(0, 40)); y = 64'($urandom_range(0, 40)); end
        2: begin x[62:0] = ONES[62:0]; y[62:0] = '0; end
        default: ;
      endcase
      e = ref_op(x, y, f);
      issue(x, y, f, sc, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk++;
      if ({lat[7:0], result, cout, zf, sf, of} !== {8'd4, e}) begin
        err++;
        $display("FAIL rand_%0d f=%0d a=%h b=%h: got %h want %h", i, f, x, y,
                 {lat[7:0], result, cout, zf, sf, of}, {8'd4, e});
      end
      hand(sc, e);
      chk++;
      if ({cc_zf, cc_sf, cc_of} !== cc_m) begin
        err++;
        $display("FAIL rand_cc_%0d: got %b want %b", i,
                 {cc_zf, cc_sf, cc_of}, cc_m);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sub_basic;
    test_wrap;
    test_zero_cc;
    test_add_of;
    test_back_to_back;
    test_reset_busy;
    test_single_cycle;
    test_random;
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_cc_iter.md
Name: alu_cc_iter

Overview:
- Parametrised, multi-cycle successor to the 64-bit combinational SUB unit.
- Performs the Y86 OPq operations ADD, SUB, AND and XOR on W-bit operands, CHUNK bits per clock, with the carry held in a register between chunks.
- Produces the result, carry-out and ZF/SF/OF flags, and holds an architectural condition-code register that updates only when the operation requests it.
- Sits in the execute stage of the sequential core, with valid/ready handshakes on both sides.

Parameters:
- W, 64: operand and result width. Must satisfy W % CHUNK == 0.
- CHUNK, 16: bits processed per cycle. N = W/CHUNK cycles per operation; CHUNK == W gives single-cycle operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- ifun  in  2  0=ADD, 1=SUB, 2=AND, 3=XOR.
- a  in  W  first operand.
- b  in  W  second operand.
- set_cc  in  1  when 1, the CC register updates when this operation's result is taken.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer takes the result.
- result  out  W  ADD: a+b; SUB: a-b; AND: a&b; XOR: a^b.
- cout  out  1  ADD: carry-out. SUB: 1 = no borrow (a >= b unsigned). AND/XOR: 0.
- zf  out  1  result == 0.
- sf  out  1  result[W-1].
- of  out  1  signed overflow of the ALU result.
- cc_zf  out  1  registered architectural ZF.
- cc_sf  out  1  registered architectural SF.
- cc_of  out  1  registered architectural OF.

Behaviour:
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Reset values: state = IDLE, so in_ready = 1. All of the following are 0: out_valid, result, cout, zf, sf, of, cc_zf, cc_sf, cc_of, chunk index, carry register.
- IDLE:
  - On in_valid: latch a, b, ifun, set_cc; idx <= 0; carry <= (ifun == SUB); go to BUSY.
  - Without in_valid: stay in IDLE.
- BUSY, on each edge:
  - Process slice idx. ADD/SUB use a_slice + (b_slice or ~b_slice) + carry; the slice result is written into result[idx*CHUNK +: CHUNK] and carry <= slice carry-out. AND/XOR are bitwise per slice and leave the carry unchanged.
  - Accumulate a running zero flag across slices.
  - idx increments. On the edge that processes idx == N-1, go to DONE with cout, zf, sf and of final.
- Latency: the operation is accepted at edge k and out_valid is high after edge k+N. Throughput is one operation per N+2 cycles at minimum, because DONE must return to IDLE.
- Flag rules:
  - ADD: of = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]).
  - SUB: of = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]).
  - AND/XOR: of = 0, cout = 0.
- DONE:
  - result and flags stay stable while out_ready == 0, for any number of cycles.
  - in_valid is ignored while in DONE (in_ready is 0).
  - On out_ready: go to IDLE. If the latched set_cc is 1, cc_zf/cc_sf/cc_of <= zf/sf/of on that same edge; otherwise the CC register is unchanged.
- Outputs after DONE: result and flags hold their last values in IDLE and BUSY but are meaningful only when out_valid = 1.
- Reset has priority over all other inputs. Reset mid-BUSY or in DONE aborts the operation: no result handshake occurs and the CC register is cleared to 0.
- Wrap-around: modular arithmetic mod 2^W. 0 - 1 gives all-ones with cout = 0.

Decomposition:
- Package alu_pkg:
  - ifun constants IFUN_ADD, IFUN_SUB, IFUN_AND, IFUN_XOR.
  - State enum IDLE, BUSY, DONE.
- One natural combinational sub-module, alu_slice, parametrised by CHUNK:
  - Inputs: a/b slices, ifun, carry-in.
  - Outputs: slice result, carry-out.
  - Instantiated once and fed through an index mux.

Test Plan (W=64, CHUNK=16, N=4):
- SUB a=15, b=10, set_cc=1 → out_valid 4 cycles after accept. result=5, cout=1, zf=0, sf=0, of=0. CC = 0/0/0 after the handshake.
- SUB a=10, b=15 → result=0xFFFFFFFFFFFFFFFB, cout=0, sf=1, of=0. SUB a=0, b=1 → result=all-ones, cout=0, sf=1.
- SUB a=0, b=0, set_cc=1 → result=0, zf=1, cout=1, cc_zf=1. Then SUB 0xFFFFFFFFFFFFFFFF − 1 with set_cc=0 → result=0xFFFFFFFFFFFFFFFE, cout=1, cc_zf stays 1.
- ADD a=0x7FFFFFFFFFFFFFFF, b=1, set_cc=1 → result=0x8000000000000000, of=1, sf=1, cout=0, and cc_of=1 on the handshake edge. XOR a=0xF0F0, b=0xFFFF → result=0x0F0F, of=0, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → result constant, in_ready=0, the second operation is not accepted until the cycle after the handshake.
- Reset asserted in BUSY (idx=2) → after that edge: in_ready=1, out_valid=0, cc_* = 0. A new SUB 15−10 afterwards completes normally. Also run with CHUNK=64 → out_valid 1 cycle after accept.
